// File: rtl/regf_sb.sv
// regf_sb: register file with integrated busy-bit scoreboard.
//   Two registered read ports with write-first bypass from the write-back port.
//   Register 0 is hardwired to zero and is never busy.
//   A busy bit per register tracks in-flight producers so issue can stall.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_reg0/i_reg1         read indices; o_reg0/o_reg1 data, o_rdy0/o_rdy1 ready
//   i_wb_en/_reg/_val     write-back port (writes data, clears busy)
//   i_iss_en/i_iss_reg    issue: marks destination busy
//   i_flush               clears all busy bits
//   o_busy                current busy vector (flop output)
module regf_sb #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [AW-1:0]    i_reg0,
  input  logic [AW-1:0]    i_reg1,
  input  logic             i_wb_en,
  input  logic [AW-1:0]    i_wb_reg,
  input  logic [WIDTH-1:0] i_wb_val,
  input  logic             i_iss_en,
  input  logic [AW-1:0]    i_iss_reg,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_reg0,
  output logic [WIDTH-1:0] o_reg1,
  output logic             o_rdy0,
  output logic             o_rdy1,
  output logic [NREGS-1:0] o_busy
);

  logic [WIDTH-1:0] mem [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt_c;
  logic             wb_hit_c;
  logic [WIDTH-1:0] rd0_c;
  logic [WIDTH-1:0] rd1_c;
  logic             rdy0_c;
  logic             rdy1_c;

  assign o_busy = busy;

  // Write-back to index 0 is discarded entirely.
  assign wb_hit_c = i_wb_en && (i_wb_reg != AW'(0));

  // Read data with write-first bypass; index 0 reads zero.
  always_comb begin
    rd0_c = mem[i_reg0];
    rd1_c = mem[i_reg1];
    if (wb_hit_c && (i_wb_reg == i_reg0)) rd0_c = i_wb_val;
    if (wb_hit_c && (i_wb_reg == i_reg1)) rd1_c = i_wb_val;
    if (i_reg0 == AW'(0)) rd0_c = '0;
    if (i_reg1 == AW'(0)) rd1_c = '0;
  end

  // Ready uses busy state before this cycle's issue/flush update.
  always_comb begin
    rdy0_c = (i_reg0 == AW'(0)) || !busy[i_reg0] || (i_wb_en && (i_wb_reg == i_reg0));
    rdy1_c = (i_reg1 == AW'(0)) || !busy[i_reg1] || (i_wb_en && (i_wb_reg == i_reg1));
  end

  // Busy update: flush beats issue, issue set beats write-back clear.
  always_comb begin
    busy_nxt_c = busy;
    if (i_flush) begin
      busy_nxt_c = '0;
    end else begin
      if (wb_hit_c) busy_nxt_c[i_wb_reg] = 1'b0;
      if (i_iss_en && (i_iss_reg != AW'(0))) busy_nxt_c[i_iss_reg] = 1'b1;
    end
    busy_nxt_c[0] = 1'b0;
  end

  // Storage array; entry 0 is only ever written by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
    end else if (wb_hit_c) begin
      mem[i_wb_reg] <= i_wb_val;
    end
  end

  // Scoreboard state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) busy <= '0;
    else       busy <= busy_nxt_c;
  end

  // Registered read ports.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_reg0 <= '0;
      o_reg1 <= '0;
      o_rdy0 <= 1'b1;
      o_rdy1 <= 1'b1;
    end else begin
      o_reg0 <= rd0_c;
      o_reg1 <= rd1_c;
      o_rdy0 <= rdy0_c;
      o_rdy1 <= rdy1_c;
    end
  end

endmodule

// File: tb/tb_regf_sb.sv
// tb_regf_sb: scoreboard-based bench for regf_sb (WIDTH=32, NREGS=32).
module tb_regf_sb;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [AW-1:0]    i_reg0, i_reg1, i_wb_reg, i_iss_reg;
  logic             i_wb_en, i_iss_en, i_flush;
  logic [WIDTH-1:0] i_wb_val;
  logic [WIDTH-1:0] o_reg0, o_reg1;
  logic             o_rdy0, o_rdy1;
  logic [NREGS-1:0] o_busy;

  regf_sb #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_reg0(i_reg0), .i_reg1(i_reg1),
    .i_wb_en(i_wb_en), .i_wb_reg(i_wb_reg), .i_wb_val(i_wb_val),
    .i_iss_en(i_iss_en), .i_iss_reg(i_iss_reg), .i_flush(i_flush),
    .o_reg0(o_reg0), .o_reg1(o_reg1), .o_rdy0(o_rdy0), .o_rdy1(o_rdy1),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [WIDTH-1:0] r0;
    logic [WIDTH-1:0] r1;
    logic             rdy0;
    logic             rdy1;
    logic [NREGS-1:0] busy;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] mem_m [NREGS];
  logic [NREGS-1:0] busy_m;
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NREGS); i++) mem_m[i] = '0;
    busy_m = '0;
  endtask

  // Drive one cycle, predict outputs from the reference model, compare after the edge.
  task automatic cycle(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input logic wb_en, input logic [AW-1:0] wb_reg, input logic [WIDTH-1:0] wb_val,
                       input logic iss_en, input logic [AW-1:0] iss_reg, input logic flush);
    exp_t e;
    exp_t got;
    @(negedge i_clk);
    i_reg0 = r0; i_reg1 = r1;
    i_wb_en = wb_en; i_wb_reg = wb_reg; i_wb_val = wb_val;
    i_iss_en = iss_en; i_iss_reg = iss_reg; i_flush = flush;
    e.r0 = (r0 == 0) ? '0 : (wb_en && wb_reg == r0) ? wb_val : mem_m[r0];
    e.r1 = (r1 == 0) ? '0 : (wb_en && wb_reg == r1) ? wb_val : mem_m[r1];
    e.rdy0 = (r0 == 0) || !busy_m[r0] || (wb_en && wb_reg == r0);
    e.rdy1 = (r1 == 0) || !busy_m[r1] || (wb_en && wb_reg == r1);
    if (wb_en && wb_reg != 0) mem_m[wb_reg] = wb_val;
    if (flush) busy_m = '0;
    else begin
      if (wb_en && wb_reg != 0) busy_m[wb_reg] = 1'b0;
      if (iss_en && iss_reg != 0) busy_m[iss_reg] = 1'b1;
    end
    e.busy = busy_m;
    sb_q.push_back(e);
    @(posedge i_clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 64'(1), 64'(0));
    end else begin
      e = sb_q.pop_front();
      got = '{o_reg0, o_reg1, o_rdy0, o_rdy1, o_busy};
      check("reg0", 64'(got.r0), 64'(e.r0));
      check("reg1", 64'(got.r1), 64'(e.r1));
      check("rdy0", 64'(got.rdy0), 64'(e.rdy0));
      check("rdy1", 64'(got.rdy1), 64'(e.rdy1));
      check("busy", 64'(got.busy), 64'(e.busy));
    end
  endtask

  task automatic rd(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    cycle(r0, r1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    i_reg0 = '0; i_reg1 = '0; i_wb_en = 1'b0; i_wb_reg = '0; i_wb_val = '0;
    i_iss_en = 1'b0; i_iss_reg = '0; i_flush = 1'b0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_reg0", 64'(o_reg0), 64'(0));
    check("rst_rdy0", 64'(o_rdy0), 64'(1));
    check("rst_busy", 64'(o_busy), 64'(0));
    @(negedge i_clk);
    i_rst = 1'b0;

    // Mid-stream asynchronous reset after writing r5.
    cycle(5'd1, 5'd2, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd12, 1'b0);
    rd(5'd5, 5'd12);
    check("pre_rst_r5", 64'(o_reg0), 64'hDEADBEEF);
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_reg0", 64'(o_reg0), 64'(0));
    check("arst_rdy0", 64'(o_rdy0), 64'(1));
    check("arst_busy", 64'(o_busy), 64'(0));
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    rd(5'd5, 5'd5);
    check("post_rst_r5", 64'(o_reg0), 64'(0));

    // Write with same-cycle read on both ports, then read from the array.
    cycle(5'd3, 5'd3, 1'b1, 5'd3, 32'h12345678, 1'b0, '0, 1'b0);
    check("byp_r3_p0", 64'(o_reg0), 64'h12345678);
    check("byp_r3_p1", 64'(o_reg1), 64'h12345678);
    rd(5'd3, 5'd3);
    check("arr_r3", 64'(o_reg0), 64'h12345678);

    // Register 0 ignores writes and issue.
    cycle(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, 1'b0);
    rd(5'd0, 5'd0);
    check("r0_data", 64'(o_reg0), 64'(0));
    check("r0_rdy", 64'(o_rdy1), 64'(1));
    cycle(5'd0, 5'd0, 1'b0, '0, '0, 1'b1, 5'd0, 1'b0);
    check("r0_busy", 64'(o_busy[0]), 64'(0));

    // Scoreboard stall and release.
    cycle(5'd1, 5'd1, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0);
    rd(5'd7, 5'd3);
    check("r7_stall", 64'(o_rdy0), 64'(0));
    cycle(5'd7, 5'd7, 1'b1, 5'd7, 32'hA5, 1'b0, '0, 1'b0);
    check("r7_rdy", 64'(o_rdy0), 64'(1));
    check("r7_data", 64'(o_reg0), 64'hA5);
    check("r7_busy", 64'(o_busy[7]), 64'(0));

    // Issue and write-back of the same register: set wins, data still lands.
    cycle(5'd1, 5'd2, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 1'b0);
    check("r9_busy", 64'(o_busy[9]), 64'(1));
    rd(5'd9, 5'd9);
    check("r9_data", 64'(o_reg0), 64'h99);
    check("r9_rdy", 64'(o_rdy0), 64'(0));

    // Issuing instruction does not stall on its own idle destination.
    cycle(5'd4, 5'd4, 1'b0, '0, '0, 1'b1, 5'd4, 1'b0);
    check("r4_rdy", 64'(o_rdy0), 64'(1));
    check("r4_busy", 64'(o_busy[4]), 64'(1));

    // Flush wins over a same-cycle issue.
    cycle(5'd0, 5'd0, 1'b0, '0, '0, 1'b1, 5'd2, 1'b0);
    cycle(5'd0, 5'd0, 1'b0, '0, '0, 1'b1, 5'd6, 1'b0);
    cycle(5'd0, 5'd0, 1'b0, '0, '0, 1'b1, 5'd31, 1'b0);
    check("pre_flush", 64'(o_busy[31]), 64'(1));
    cycle(5'd2, 5'd6, 1'b1, 5'd10, 32'h1010, 1'b1, 5'd8, 1'b1);
    check("flush_busy", 64'(o_busy), 64'(0));
    rd(5'd10, 5'd8);
    check("flush_wb_data", 64'(o_reg0), 64'h1010);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      cycle(AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
            ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regf_sb.md
# regf_sb

Parametrised register file with an integrated scoreboard for the pipelined core. It serves two registered read ports and one enabled write-back port, with register 0 hardwired to zero and write-to-read bypass in the same cycle. A per-register busy bit tracks in-flight producers, so the issue stage can stall on operands that are not yet ready. It sits between decode/issue (read and issue side) and the write-back stage.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- NREGS, 32, number of registers; power of two, ≥ 2
- AW, $clog2(NREGS), register index width (derived; not overridden)

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_reg0  in  AW  index, read port 0
- i_reg1  in  AW  index, read port 1
- i_wb_en  in  1  write-back enable
- i_wb_reg  in  AW  write-back index
- i_wb_val  in  WIDTH  write-back data
- i_iss_en  in  1  issue: mark i_iss_reg as pending
- i_iss_reg  in  AW  destination index of the issuing instruction
- i_flush  in  1  clear all busy bits (pipeline flush)
- o_reg0  out  WIDTH  read data, port 0 (registered)
- o_reg1  out  WIDTH  read data, port 1 (registered)
- o_rdy0  out  1  operand 0 not pending (registered, aligned with o_reg0)
- o_rdy1  out  1  operand 1 not pending (registered, aligned with o_reg1)
- o_busy  out  NREGS  current busy vector; bit r = register r pending

## Operation
- Storage is NREGS × WIDTH flops. Entry 0 is never written, reads as 0 and is never busy.
- **Write:** when i_wb_en is high and i_wb_reg ≠ 0, the entry takes i_wb_val at the clock edge. i_wb_reg = 0 is ignored for both data and busy.
- **Read (port k):** o_regk takes the value of entry i_regk at the edge.
  - Bypass: if i_wb_en is high and i_wb_reg = i_regk ≠ 0, o_regk takes i_wb_val (write-first).
  - i_regk = 0 always yields 0.
- **Ready:** o_rdyk takes !busy[i_regk] || (i_wb_en && i_wb_reg = i_regk).
  - Forced to 1 when i_regk = 0.
  - Computed from busy state before this cycle's issue/flush update, so an instruction issuing this cycle never stalls on its own destination.
- **Busy update per edge, in priority order:**
  1. i_flush: all bits cleared; same-cycle issue and write-back are ignored for busy, but the data write still occurs.
  2. i_iss_en with i_iss_reg ≠ 0: busy[i_iss_reg] set. Set wins over a same-cycle write-back clear of the same index (new producer).
  3. i_wb_en with i_wb_reg ≠ 0: busy[i_wb_reg] cleared.
- Write-back to a non-busy register is legal: data is written and busy stays 0.
- Both read ports may address the same register, including the one being written.

## Timing
- Read latency is 1 cycle: index at edge N gives data and ready valid after edge N.
- A write at edge N is visible through the array from edge N+1. Same-cycle reads see it via bypass at edge N.
- Busy changes at edge N are visible on o_busy after edge N and affect o_rdyk for reads sampled at edge N+1.
- Reset (asynchronous, any time, including mid-operation) clears all entries, busy and o_reg0/o_reg1 to 0, and sets o_rdy0/o_rdy1 to 1.
  - While i_rst is high, all inputs are ignored.
  - First active edge is the first edge with i_rst low.
- No combinational path from any input to any output except through o_busy, which is a direct flop output.

## Test plan
- **Reset:** assert i_rst mid-stream after writing 0xDEADBEEF to r5, then release and read r5. Expect o_reg0=0, o_rdy0=1, o_busy=0.
- **Write/read/bypass:** write r3=0x12345678 while reading r3 on both ports in the same cycle. Expect o_reg0=o_reg1=0x12345678 next cycle, and r3 still reads 0x12345678 a cycle later.
- **Register 0:**
  - Write r0=0xFFFFFFFF, then read r0. Expect 0, o_rdy=1.
  - Issue r0. Expect o_busy[0] stays 0.
- **Scoreboard:**
  - Issue r7, then read r7 next cycle. Expect o_rdy0=0.
  - Write back r7=0xA5 while reading r7. Expect o_rdy0=1 and o_reg0=0xA5 next cycle, o_busy[7]=0.
- **Simultaneous events:**
  - Issue r9 and write back r9 in the same cycle. Expect o_busy[9]=1 and data updated.
  - Issue r4 and read r4 in the same cycle with r4 idle. Expect o_rdy0=1.
- **Flush:** set r2, r6 and r31 busy, then assert i_flush together with an issue of r8. Expect o_busy=0 next cycle.
